// File: rtl/wb_stage.sv
// MEM/WB pipeline register with load alignment/extension, misaligned-load detection,
// register-file write/link port drive, WB forwarding source and retired-instruction counter.
module wb_stage #(
    parameter int DW       = 32,
    parameter int LINK_OFS = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall_i,
    input  logic          flush_i,
    input  logic          mem_valid_i,
    input  logic          mem_regwrite_i,
    input  logic [4:0]    mem_wa_i,
    input  logic [DW-1:0] mem_alu_i,
    input  logic [DW-1:0] mem_rdata_i,
    input  logic [1:0]    mem_addr_lo_i,
    input  logic [2:0]    mem_ldtype_i,
    input  logic [1:0]    mem_link_i,
    input  logic [4:0]    mem_linkaddr_i,
    input  logic [DW-1:0] mem_pc_i,
    output logic          RegWrite,
    output logic [4:0]    wa_o,
    output logic [DW-1:0] wd_o,
    output logic [1:0]    Link,
    output logic [4:0]    LinkAddr,
    output logic [DW-1:0] LinkData,
    output logic          fwd_valid_o,
    output logic [4:0]    fwd_wa_o,
    output logic [DW-1:0] fwd_wd_o,
    output logic          misalign_o,
    output logic [DW-1:0] instret_o
);

    typedef enum logic [2:0] {
        LD_ALU = 3'b000,
        LD_W   = 3'b001,
        LD_B   = 3'b010,
        LD_BU  = 3'b011,
        LD_H   = 3'b100,
        LD_HU  = 3'b101
    } ld_type_e;

    logic          v_q;
    logic          rw_q;
    logic          mis_q;
    logic [4:0]    wa_q;
    logic [4:0]    la_q;
    logic [1:0]    link_q;
    logic [DW-1:0] wd_q;
    logic [DW-1:0] pc_q;
    logic [DW-1:0] cnt_q;

    logic [7:0]    lane_byte;
    logic [15:0]   lane_half;
    logic [DW-1:0] fmt;
    logic          mis;

    // Load formatting happens before the flops so WB outputs are flop-direct.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path can infer a latch.
        lane_byte = 8'(mem_rdata_i >> {mem_addr_lo_i, 3'b000});
        lane_half = 16'(mem_rdata_i >> {mem_addr_lo_i[1], 4'b0000});
        fmt       = mem_alu_i;
        mis       = 1'b0;
        case (ld_type_e'(mem_ldtype_i))
            LD_W: begin
                fmt = mem_rdata_i;
                mis = (mem_addr_lo_i != 2'b00);
            end
            LD_B:  fmt = {{(DW-8){lane_byte[7]}}, lane_byte};
            LD_BU: fmt = {{(DW-8){1'b0}}, lane_byte};
            LD_H: begin
                fmt = {{(DW-16){lane_half[15]}}, lane_half};
                mis = mem_addr_lo_i[0];
            end
            LD_HU: begin
                fmt = {{(DW-16){1'b0}}, lane_half};
                mis = mem_addr_lo_i[0];
            end
            default: fmt = mem_alu_i;
        endcase
        mis = mis & mem_valid_i;
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
        if (rst) begin
            v_q    <= 1'b0;
            rw_q   <= 1'b0;
            mis_q  <= 1'b0;
            wa_q   <= '0;
            la_q   <= '0;
            link_q <= '0;
            wd_q   <= '0;
            pc_q   <= '0;
            cnt_q  <= '0;
        end else if (flush_i) begin
            // Only control is cleared; data flops keep stale, unobservable contents.
            v_q    <= 1'b0;
            rw_q   <= 1'b0;
            link_q <= '0;
            mis_q  <= 1'b0;
        end else if (!stall_i) begin
            v_q    <= mem_valid_i;
            rw_q   <= mem_regwrite_i & ~mis;
            mis_q  <= mis;
            wa_q   <= mem_wa_i;
            la_q   <= mem_linkaddr_i;
            link_q <= mis ? 2'b00 : mem_link_i;
            wd_q   <= fmt;
            pc_q   <= mem_pc_i + DW'(LINK_OFS);
            if (mem_valid_i && !mis) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign RegWrite    = v_q & rw_q;
    assign Link        = v_q ? link_q : 2'b00;
    assign wa_o        = wa_q;
    assign wd_o        = wd_q;
    assign LinkAddr    = la_q;
    assign LinkData    = pc_q;
    assign fwd_valid_o = RegWrite & (wa_q != 5'd0);
    assign fwd_wa_o    = wa_q;
    assign fwd_wd_o    = wd_q;
    assign misalign_o  = v_q & mis_q;
    assign instret_o   = cnt_q;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: reset, directed vector table, stall/flush
// sequences, counter wrap and randomized traffic against a behavioural model.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst, stall, flush;
    logic        mem_valid, mem_regwrite;
    logic [4:0]  mem_wa, mem_linkaddr;
    logic [31:0] mem_alu, mem_rdata, mem_pc;
    logic [1:0]  mem_addr_lo, mem_link;
    logic [2:0]  mem_ldtype;

    logic        reg_write, fwd_valid, misalign;
    logic [4:0]  wa, link_addr, fwd_wa;
    logic [1:0]  link;
    logic [31:0] wd, link_data, fwd_wd, instret;

    int checks = 0;
    int errors = 0;

    // Behavioural model: expected outputs as seen after the most recent edge.
    logic        m_rw, m_mis, m_known;
    logic [1:0]  m_link;
    logic [4:0]  m_wa, m_la;
    logic [31:0] m_wd, m_ldata, m_cnt;

    always #5 clk = ~clk;

    wb_stage #(.DW(32), .LINK_OFS(4)) dut (
        .clk(clk), .rst(rst), .stall_i(stall), .flush_i(flush),
        .mem_valid_i(mem_valid), .mem_regwrite_i(mem_regwrite), .mem_wa_i(mem_wa),
        .mem_alu_i(mem_alu), .mem_rdata_i(mem_rdata), .mem_addr_lo_i(mem_addr_lo),
        .mem_ldtype_i(mem_ldtype), .mem_link_i(mem_link), .mem_linkaddr_i(mem_linkaddr),
        .mem_pc_i(mem_pc),
        .RegWrite(reg_write), .wa_o(wa), .wd_o(wd), .Link(link), .LinkAddr(link_addr),
        .LinkData(link_data), .fwd_valid_o(fwd_valid), .fwd_wa_o(fwd_wa), .fwd_wd_o(fwd_wd),
        .misalign_o(misalign), .instret_o(instret)
    );

    typedef struct {
        logic        valid, rw;
        logic [4:0]  wa;
        logic [31:0] alu, rdata;
        logic [1:0]  lo;
        logic [2:0]  ld;
        logic [1:0]  lnk;
        logic [4:0]  la;
        logic [31:0] pc;
        logic        e_rw;
        logic [31:0] e_wd;
        logic [1:0]  e_link;
        logic [4:0]  e_la;
        logic [31:0] e_ldata;
        logic        e_mis, e_fwd;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_wd(input logic [2:0] ld, input logic [31:0] rd,
                                           input logic [1:0] lo, input logic [31:0] alu);
        int unsigned b, h;
        b = (rd >> (8 * lo)) & 32'd255;
        h = (rd >> (16 * (lo / 2))) & 32'd65535;
        case (ld)
            3'd1:    return rd;
            3'd2:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'd3:    return b;
            3'd4:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'd5:    return h;
            default: return alu;
        endcase
    endfunction

    function automatic logic ref_mis(input logic v, input logic [2:0] ld, input logic [1:0] lo);
        return v && ((ld == 3'd1 && lo != 2'd0) || ((ld == 3'd4 || ld == 3'd5) && lo[0]));
    endfunction

    task automatic model_tick();
        logic mis;
        if (rst) begin
            m_rw = 0; m_mis = 0; m_link = 0; m_wa = 0; m_la = 0;
            m_wd = 0; m_ldata = 0; m_cnt = 0; m_known = 1;
        end else if (flush) begin
            m_rw = 0; m_mis = 0; m_link = 0; m_known = 0;
        end else if (!stall) begin
            mis     = ref_mis(mem_valid, mem_ldtype, mem_addr_lo);
            m_rw    = mem_valid && mem_regwrite && !mis;
            m_link  = (mem_valid && !mis) ? mem_link : 2'b00;
            m_mis   = mis;
            m_wa    = mem_wa;
            m_la    = mem_linkaddr;
            m_wd    = ref_wd(mem_ldtype, mem_rdata, mem_addr_lo, mem_alu);
            m_ldata = mem_pc + 32'd4;
            m_known = 1;
            if (mem_valid && !mis) m_cnt = m_cnt + 32'd1;
        end
    endtask

    task automatic compare(input string tag);
        check({tag, ".RegWrite"}, 32'(reg_write), 32'(m_rw));
        check({tag, ".Link"}, 32'(link), 32'(m_link));
        check({tag, ".misalign"}, 32'(misalign), 32'(m_mis));
        check({tag, ".fwd_valid"}, 32'(fwd_valid), 32'(m_rw && (m_wa != 5'd0)));
        check({tag, ".instret"}, instret, m_cnt);
        if (m_known) begin
            check({tag, ".wa"}, 32'(wa), 32'(m_wa));
            check({tag, ".wd"}, wd, m_wd);
            check({tag, ".fwd_wa"}, 32'(fwd_wa), 32'(m_wa));
            check({tag, ".fwd_wd"}, fwd_wd, m_wd);
            check({tag, ".LinkAddr"}, 32'(link_addr), 32'(m_la));
            check({tag, ".LinkData"}, link_data, m_ldata);
        end
    endtask

    // Inputs are driven at negedge; one posedge captures; outputs compared at the next negedge.
    task automatic step(input string tag);
        model_tick();
        @(posedge clk);
        @(negedge clk);
        compare(tag);
    endtask

    task automatic drive(input logic v, input logic r, input logic [4:0] a, input logic [31:0] alu,
                         input logic [31:0] rd, input logic [1:0] lo, input logic [2:0] ld,
                         input logic [1:0] lk, input logic [4:0] la, input logic [31:0] pc);
        mem_valid = v; mem_regwrite = r; mem_wa = a; mem_alu = alu; mem_rdata = rd;
        mem_addr_lo = lo; mem_ldtype = ld; mem_link = lk; mem_linkaddr = la; mem_pc = pc;
    endtask

    localparam logic [31:0] R = 32'h80FF_7F01;

    initial begin
        m_rw = 0; m_mis = 0; m_link = 0; m_wa = 0; m_la = 0;
        m_wd = 0; m_ldata = 0; m_cnt = 0; m_known = 0;

        vecs[0]  = '{1, 1, 5,  32'h1234_5678, R, 0, 0, 0, 0, 32'h100, 1, 32'h1234_5678, 0, 0, 32'h104, 0, 1};
        vecs[1]  = '{1, 1, 6,  32'h0000_DEAD, R, 3, 2, 0, 0, 32'h104, 1, 32'hFFFF_FF80, 0, 0, 32'h108, 0, 1};
        vecs[2]  = '{1, 1, 7,  32'h0,         R, 1, 3, 0, 0, 32'h108, 1, 32'h0000_007F, 0, 0, 32'h10C, 0, 1};
        vecs[3]  = '{1, 1, 8,  32'h0,         R, 2, 4, 0, 0, 32'h10C, 1, 32'hFFFF_80FF, 0, 0, 32'h110, 0, 1};
        vecs[4]  = '{1, 1, 9,  32'h0,         R, 0, 5, 0, 0, 32'h110, 1, 32'h0000_7F01, 0, 0, 32'h114, 0, 1};
        vecs[5]  = '{1, 1, 10, 32'h0,         R, 0, 1, 0, 0, 32'h114, 1, R,             0, 0, 32'h118, 0, 1};
        vecs[6]  = '{1, 1, 11, 32'h0,         R, 2, 1, 0, 0, 32'h118, 0, R,             0, 0, 32'h11C, 1, 0};
        vecs[7]  = '{1, 1, 12, 32'h0,         R, 1, 4, 0, 0, 32'h11C, 0, R,             0, 0, 32'h120, 1, 0};
        vecs[8]  = '{1, 1, 13, 32'h0,         R, 3, 1, 1, 0, 32'h120, 0, R,             0, 0, 32'h124, 1, 0};
        vecs[9]  = '{1, 0, 0,  32'h55,        R, 0, 0, 1, 0, 32'h40,  0, 32'h55,        1, 0, 32'h44,  0, 0};
        vecs[10] = '{1, 1, 9,  32'h77,        R, 0, 0, 2, 7, 32'h200, 1, 32'h77,        2, 7, 32'h204, 0, 1};
        vecs[11] = '{1, 1, 0,  32'h99,        R, 0, 0, 0, 0, 32'h300, 1, 32'h99,        0, 0, 32'h304, 0, 0};
        vecs[12] = '{1, 1, 3,  32'hCAFE_F00D, R, 2, 6, 0, 0, 32'h400, 1, 32'hCAFE_F00D, 0, 0, 32'h404, 0, 1};
        vecs[13] = '{1, 1, 4,  32'h0BAD_BEEF, R, 1, 7, 0, 0, 32'h500, 1, 32'h0BAD_BEEF, 0, 0, 32'h504, 0, 1};
        vecs[14] = '{0, 1, 5,  32'h1,         R, 2, 1, 1, 3, 32'h600, 0, R,             0, 3, 32'h604, 0, 0};

        // Reset held for two cycles with live, nonzero inputs.
        rst = 1; stall = 1; flush = 1;
        drive(1, 1, 5'd17, 32'hFFFF_FFFF, R, 2'd3, 3'd2, 2'd1, 5'd9, 32'h1000);
        @(negedge clk);
        step("rst0");
        step("rst1");
        rst = 0; stall = 0; flush = 0;

        foreach (vecs[i]) begin
            drive(vecs[i].valid, vecs[i].rw, vecs[i].wa, vecs[i].alu, vecs[i].rdata,
                  vecs[i].lo, vecs[i].ld, vecs[i].lnk, vecs[i].la, vecs[i].pc);
            step($sformatf("vec%0d", i));
            check($sformatf("vec%0d.t_RegWrite", i), 32'(reg_write), 32'(vecs[i].e_rw));
            check($sformatf("vec%0d.t_Link", i), 32'(link), 32'(vecs[i].e_link));
            check($sformatf("vec%0d.t_misalign", i), 32'(misalign), 32'(vecs[i].e_mis));
            check($sformatf("vec%0d.t_fwd_valid", i), 32'(fwd_valid), 32'(vecs[i].e_fwd));
            check($sformatf("vec%0d.t_LinkAddr", i), 32'(link_addr), 32'(vecs[i].e_la));
            check($sformatf("vec%0d.t_LinkData", i), link_data, vecs[i].e_ldata);
            if (!vecs[i].e_mis) check($sformatf("vec%0d.t_wd", i), wd, vecs[i].e_wd);
        end

        // Instruction A captured, then held through three stall cycles while inputs change.
        drive(1, 1, 5'd12, 32'hA5A5_A5A5, R, 2'd0, 3'd0, 2'd1, 5'd4, 32'h800);
        step("A");
        stall = 1;
        for (int k = 0; k < 3; k++) begin
            drive(1, 1, 5'(20 + k), 32'h1111_0000 + 32'(k), R, 2'd0, 3'd0, 2'd2, 5'd6, 32'h900);
            step($sformatf("stall%0d", k));
            check($sformatf("stall%0d.hold_wd", k), wd, 32'hA5A5_A5A5);
            check($sformatf("stall%0d.hold_Link", k), 32'(link), 32'd1);
        end
        flush = 1;
        step("stall_flush");
        check("stall_flush.RegWrite0", 32'(reg_write), 32'd0);
        check("stall_flush.Link0", 32'(link), 32'd0);
        stall = 0; flush = 0;
        drive(0, 0, 5'd0, 32'h0, R, 2'd0, 3'd0, 2'd0, 5'd0, 32'hA00);
        step("bubble");

        // Counter wrap: preload the count just below wrap, then retire two instructions.
        force dut.cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.cnt_q;
        m_cnt = 32'hFFFF_FFFF;
        drive(1, 1, 5'd2, 32'h42, R, 2'd0, 3'd0, 2'd0, 5'd0, 32'hB00);
        step("wrap0");
        check("wrap0.instret_zero", instret, 32'd0);
        step("wrap1");

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            rst   = ($urandom_range(0, 49) == 0);
            flush = ($urandom_range(0, 9) == 0);
            stall = ($urandom_range(0, 4) == 0);
            drive($urandom_range(0, 3) != 0, 1'($urandom), 5'($urandom), $urandom, $urandom,
                  2'($urandom), 3'($urandom), 2'($urandom_range(0, 2)), 5'($urandom), $urandom);
            step($sformatf("rnd%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
